// File: rtl/eth_regs_bus.sv
// Addressed req/ack register bank for the 10/100 MAC: atomic 48-bit address commit,
// write-lock while the MAC runs, sticky interrupt status with mask.
module eth_regs_bus #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          ack_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  input  logic [7:0]    irq_set_i,
  output logic          irq_o,
  output logic [47:0]   mac_adr_o,
  output logic [47:0]   multicast_adr_o,
  output logic [4:0]    txalr_o,
  output logic [9:0]    minlr_o,
  output logic [12:0]   maxlr_o,
  output logic          cr_o,
  output logic [11:0]   rxcr_o,
  output logic [1:0]    txddr_o,
  output logic [7:0]    rxdtr_o,
  output logic [15:0]   rxdwtr_o
);

  localparam int NW = (DW == 16) ? 3 : 2;

  typedef enum logic [1:0] {IDLE, RESP, DRAIN} state_t;
  state_t state_q, state_d;

  logic [47:0]   mac_q, mac_d, mc_q, mc_d;
  logic [31:0]   mac_sh_q, mac_sh_d, mc_sh_q, mc_sh_d;
  logic [4:0]    txalr_q, txalr_d;
  logic [9:0]    minlr_q, minlr_d;
  logic [12:0]   maxlr_q, maxlr_d;
  logic          cr_q, cr_d;
  logic [11:0]   rxcr_q, rxcr_d;
  logic [1:0]    txddr_q, txddr_d;
  logic [7:0]    rxdtr_q, rxdtr_d;
  logic [15:0]   rxdwtr_q, rxdwtr_d;
  logic [7:0]    isr_q, isr_d, imr_q, imr_d, isr_clr;
  logic          irq_q, irq_d;
  logic [DW-1:0] rdata_q, rdata_d, rd_w;
  logic          err_q, err_d;

  logic          access, mapped, lockable, locked;
  logic [31:0]   idx, wd32;

  assign access = (state_q == IDLE) && req_i;
  assign idx    = 32'(addr_i);
  assign wd32   = 32'(wdata_i);

  // State register and all datapath registers
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q  <= IDLE;
      mac_q    <= '0;
      mc_q     <= '0;
      mac_sh_q <= '0;
      mc_sh_q  <= '0;
      txalr_q  <= 5'h10;
      minlr_q  <= 10'h040;
      maxlr_q  <= 13'h05EE;
      cr_q     <= 1'b0;
      rxcr_q   <= 12'h800;
      txddr_q  <= '0;
      rxdtr_q  <= 8'h20;
      rxdwtr_q <= 16'h1000;
      isr_q    <= '0;
      imr_q    <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mac_q    <= mac_d;
      mc_q     <= mc_d;
      mac_sh_q <= mac_sh_d;
      mc_sh_q  <= mc_sh_d;
      txalr_q  <= txalr_d;
      minlr_q  <= minlr_d;
      maxlr_q  <= maxlr_d;
      cr_q     <= cr_d;
      rxcr_q   <= rxcr_d;
      txddr_q  <= txddr_d;
      rxdtr_q  <= rxdtr_d;
      rxdwtr_q <= rxdwtr_d;
      isr_q    <= isr_d;
      imr_q    <= imr_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = RESP;
      RESP:    state_d = DRAIN;
      DRAIN:   if (!req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o   = (state_q == RESP);
    rdata_o = ack_o ? rdata_q : '0;
    err_o   = ack_o & err_q;
  end

  // Address decode and read mux; address words are DW-wide slices of the 48-bit value
  always_comb begin
    rd_w     = '0;
    mapped   = 1'b1;
    lockable = 1'b0;
    if (idx < NW) begin
      lockable = 1'b1;
      rd_w     = DW'({16'h0, mac_q} >> (idx * DW));
    end else if (idx >= 4 && idx < 4 + NW) begin
      lockable = 1'b1;
      rd_w     = DW'({16'h0, mc_q} >> ((idx - 4) * DW));
    end else begin
      case (idx)
        32'd8:   rd_w = DW'(txalr_q);
        32'd9:   begin rd_w = DW'(minlr_q); lockable = 1'b1; end
        32'd10:  begin rd_w = DW'(maxlr_q); lockable = 1'b1; end
        32'd11:  rd_w = DW'(cr_q);
        32'd12:  rd_w = DW'(rxcr_q);
        32'd13:  rd_w = DW'(txddr_q);
        32'd14:  rd_w = DW'(rxdtr_q);
        32'd15:  rd_w = DW'(rxdwtr_q);
        32'd16:  rd_w = DW'(isr_q);
        32'd17:  rd_w = DW'(imr_q);
        default: mapped = 1'b0;
      endcase
    end
    locked = lockable & cr_q;
  end

  always_comb begin
    mac_d    = mac_q;
    mc_d     = mc_q;
    mac_sh_d = mac_sh_q;
    mc_sh_d  = mc_sh_q;
    txalr_d  = txalr_q;
    minlr_d  = minlr_q;
    maxlr_d  = maxlr_q;
    cr_d     = cr_q;
    rxcr_d   = rxcr_q;
    txddr_d  = txddr_q;
    rxdtr_d  = rxdtr_q;
    rxdwtr_d = rxdwtr_q;
    imr_d    = imr_q;
    isr_clr  = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (access) begin
      rdata_d = we_i ? '0 : rd_w;
      err_d   = !mapped || (we_i && locked);
      if (we_i && mapped && !locked) begin
        // Lower address words only fill the shadow; the top word commits all 48 bits at once
        if (idx < NW) begin
          if (idx == NW - 1)     mac_d = {wd32[15:0], mac_sh_q};
          else if (DW == 32)     mac_sh_d = wd32;
          else if (idx == 0)     mac_sh_d[15:0] = wd32[15:0];
          else                   mac_sh_d[31:16] = wd32[15:0];
        end else if (idx >= 4 && idx < 4 + NW) begin
          if (idx == 4 + NW - 1) mc_d = {wd32[15:0], mc_sh_q};
          else if (DW == 32)     mc_sh_d = wd32;
          else if (idx == 4)     mc_sh_d[15:0] = wd32[15:0];
          else                   mc_sh_d[31:16] = wd32[15:0];
        end else begin
          case (idx)
            32'd8:   txalr_d  = wd32[4:0];
            32'd9:   minlr_d  = wd32[9:0];
            32'd10:  maxlr_d  = wd32[12:0];
            32'd11:  cr_d     = wd32[0];
            32'd12:  rxcr_d   = wd32[11:0] & 12'hFF9;
            32'd13:  txddr_d  = wd32[1:0];
            32'd14:  rxdtr_d  = wd32[7:0];
            32'd15:  rxdwtr_d = wd32[15:0];
            32'd16:  isr_clr  = wd32[7:0];
            32'd17:  imr_d    = wd32[7:0];
            default: ;
          endcase
        end
      end
    end
    isr_d = (isr_q & ~isr_clr) | irq_set_i;
    irq_d = |(isr_q & imr_q);
  end

  assign irq_o           = irq_q;
  assign mac_adr_o       = mac_q;
  assign multicast_adr_o = mc_q;
  assign txalr_o         = txalr_q;
  assign minlr_o         = minlr_q;
  assign maxlr_o         = maxlr_q;
  assign cr_o            = cr_q;
  assign rxcr_o          = rxcr_q;
  assign txddr_o         = txddr_q;
  assign rxdtr_o         = rxdtr_q;
  assign rxdwtr_o        = rxdwtr_q;

endmodule

// File: tb/tb_eth_regs_bus.sv
// Directed and random bus traffic against eth_regs_bus (DW=16), checked
// against a register-map model held in plain variables.
module tb_eth_regs_bus;

  logic        clk_i = 1'b0;
  logic        res_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [15:0] wdata_i = '0;
  logic [7:0]  irq_set_i = '0;
  logic        ack_o, err_o, irq_o, cr_o;
  logic [15:0] rdata_o, rxdwtr_o;
  logic [47:0] mac_adr_o, multicast_adr_o;
  logic [4:0]  txalr_o;
  logic [9:0]  minlr_o;
  logic [12:0] maxlr_o;
  logic [11:0] rxcr_o;
  logic [1:0]  txddr_o;
  logic [7:0]  rxdtr_o;

  eth_regs_bus #(.DW(16), .AW(5)) dut (
    .clk_i(clk_i), .res_i(res_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .irq_set_i(irq_set_i), .irq_o(irq_o), .mac_adr_o(mac_adr_o),
    .multicast_adr_o(multicast_adr_o), .txalr_o(txalr_o), .minlr_o(minlr_o),
    .maxlr_o(maxlr_o), .cr_o(cr_o), .rxcr_o(rxcr_o), .txddr_o(txddr_o),
    .rxdtr_o(rxdtr_o), .rxdwtr_o(rxdwtr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: committed addresses, pending lower words, and the plain registers
  logic [47:0] m_mac, m_mc;
  logic [31:0] m_msh, m_csh;
  logic [4:0]  m_txalr;
  logic [9:0]  m_minlr;
  logic [12:0] m_maxlr;
  logic        m_cr;
  logic [11:0] m_rxcr;
  logic [1:0]  m_txddr;
  logic [7:0]  m_rxdtr, m_isr, m_imr;
  logic [15:0] m_rxdwtr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mac = '0; m_mc = '0; m_msh = '0; m_csh = '0;
    m_txalr = 5'h10; m_minlr = 10'h040; m_maxlr = 13'h05EE; m_cr = 1'b0;
    m_rxcr = 12'h800; m_txddr = '0; m_rxdtr = 8'h20; m_rxdwtr = 16'h1000;
    m_isr = '0; m_imr = '0;
  endtask

  function automatic bit is_mapped(input int a);
    return (a >= 0 && a <= 2) || (a >= 4 && a <= 6) || (a >= 8 && a <= 17);
  endfunction

  function automatic bit is_lockable(input int a);
    return (a >= 0 && a <= 2) || (a >= 4 && a <= 6) || a == 9 || a == 10;
  endfunction

  function automatic logic [15:0] m_read(input int a);
    logic [47:0] v;
    if (a >= 0 && a <= 2) begin v = m_mac >> (16 * a); return v[15:0]; end
    if (a >= 4 && a <= 6) begin v = m_mc >> (16 * (a - 4)); return v[15:0]; end
    case (a)
      8:  return 16'(m_txalr);
      9:  return 16'(m_minlr);
      10: return 16'(m_maxlr);
      11: return 16'(m_cr);
      12: return 16'(m_rxcr);
      13: return 16'(m_txddr);
      14: return 16'(m_rxdtr);
      15: return m_rxdwtr;
      16: return 16'(m_isr);
      17: return 16'(m_imr);
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_write(input int a, input logic [15:0] wd);
    case (a)
      0, 1: m_msh[16 * a +: 16] = wd;
      2:    m_mac = {wd, m_msh};
      4, 5: m_csh[16 * (a - 4) +: 16] = wd;
      6:    m_mc = {wd, m_csh};
      8:    m_txalr = wd[4:0];
      9:    m_minlr = wd[9:0];
      10:   m_maxlr = wd[12:0];
      11:   m_cr = wd[0];
      12:   m_rxcr = wd[11:0] & ~12'h006;
      13:   m_txddr = wd[1:0];
      14:   m_rxdtr = wd[7:0];
      15:   m_rxdwtr = wd;
      16:   m_isr = m_isr & ~wd[7:0];
      17:   m_imr = wd[7:0];
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("mac_adr", mac_adr_o, m_mac);
    chk("multicast_adr", multicast_adr_o, m_mc);
    chk("ctl_a", {txalr_o, minlr_o, maxlr_o, cr_o}, {m_txalr, m_minlr, m_maxlr, m_cr});
    chk("ctl_b", {rxcr_o, txddr_o, rxdtr_o, rxdwtr_o}, {m_rxcr, m_txddr, m_rxdtr, m_rxdwtr});
    chk("irq", irq_o, |(m_isr & m_imr));
  endtask

  // One bus transaction; optional irq_set pulse lands on the access edge
  task automatic access(input logic we, input int a, input logic [15:0] wd, input logic [7:0] pulse);
    logic [15:0] exp_rd, rd;
    logic        exp_err, e, got;
    int          lat;
    exp_err = !is_mapped(a) || (we && is_lockable(a) && m_cr);
    exp_rd  = m_read(a);
    req_i = 1'b1; we_i = we; addr_i = 5'(a); wdata_i = wd; irq_set_i = pulse;
    lat = 0; got = 1'b0; rd = '0; e = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk_i);
      irq_set_i = '0;
      lat++;
      if (ack_o) begin got = 1'b1; rd = rdata_o; e = err_o; end
    end
    req_i = 1'b0;
    chk("ack_seen", got, 1'b1);
    if (got) begin
      chk("latency", lat, 1);
      chk("err", e, exp_err);
      if (!we) chk("rdata", rd, exp_rd);
    end
    if (we && !exp_err) model_write(a, wd);
    m_isr = m_isr | pulse;
    @(negedge clk_i);
    chk("ack_one_cycle", ack_o, 1'b0);
    @(negedge clk_i);
    check_outputs();
    $display("txn we=%0b idx=%0d wdata=%h rdata=%h err=%0b", we, a, wd, rd, e);
  endtask

  task automatic do_reset();
    req_i = 1'b0; irq_set_i = '0; res_i = 1'b1;
    repeat (2) @(negedge clk_i);
    res_i = 1'b0;
    model_reset();
    @(negedge clk_i);
  endtask

  initial begin
    int acks;
    logic [15:0] wd;
    logic        rw;
    int          a;
    logic [7:0]  p;

    do_reset();
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdata", rdata_o, 16'h0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_mac", mac_adr_o, 48'h0);
    chk("rst_mc", multicast_adr_o, 48'h0);
    chk("rst_txalr", txalr_o, 5'h10);
    chk("rst_minlr", minlr_o, 10'h040);
    chk("rst_maxlr", maxlr_o, 13'h05EE);
    chk("rst_cr", cr_o, 1'b0);
    chk("rst_rxcr", rxcr_o, 12'h800);
    chk("rst_txddr", txddr_o, 2'h0);
    chk("rst_rxdtr", rxdtr_o, 8'h20);
    chk("rst_rxdwtr", rxdwtr_o, 16'h1000);
    for (int i = 0; i <= 21; i++) access(1'b0, i, 16'h0, 8'h0);
    access(1'b0, 31, 16'h0, 8'h0);
    access(1'b1, 20, 16'hFFFF, 8'h0);

    // Atomic MAC address commit
    access(1'b1, 0, 16'h2211, 8'h0);
    access(1'b1, 1, 16'h4433, 8'h0);
    chk("mac_not_committed", mac_adr_o, 48'h0);
    access(1'b1, 2, 16'h6655, 8'h0);
    chk("mac_commit", mac_adr_o, 48'h665544332211);
    access(1'b1, 4, 16'hA1A2, 8'h0);
    access(1'b1, 5, 16'hB1B2, 8'h0);
    access(1'b1, 6, 16'hC1C2, 8'h0);
    chk("mc_commit", multicast_adr_o, 48'hC1C2B1B2A1A2);
    access(1'b1, 12, 16'hFFFF, 8'h0);
    chk("rxcr_mask", rxcr_o, 12'hFF9);

    // Write lock while cr=1
    access(1'b1, 11, 16'h0001, 8'h0);
    access(1'b1, 9, 16'h03FF, 8'h0);
    chk("minlr_locked", minlr_o, 10'h040);
    access(1'b1, 0, 16'h7777, 8'h0);
    access(1'b1, 2, 16'h8888, 8'h0);
    chk("mac_locked", mac_adr_o, 48'h665544332211);
    access(1'b1, 11, 16'h0000, 8'h0);
    access(1'b1, 9, 16'h03FF, 8'h0);
    chk("minlr_unlocked", minlr_o, 10'h3FF);

    // Interrupt set/clear priority
    @(negedge clk_i); irq_set_i = 8'h05;
    @(negedge clk_i); irq_set_i = 8'h00;
    m_isr = m_isr | 8'h05;
    access(1'b1, 17, 16'h0004, 8'h0);
    access(1'b0, 16, 16'h0, 8'h0);
    chk("irq_on", irq_o, 1'b1);
    access(1'b1, 16, 16'h0004, 8'h04);
    access(1'b0, 16, 16'h0, 8'h0);
    chk("irq_still_on", irq_o, 1'b1);
    access(1'b1, 16, 16'h0004, 8'h00);
    chk("irq_off", irq_o, 1'b0);

    // Held request gives one ack; re-request after one low cycle gives another
    acks = 0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 5'd8;
    for (int i = 0; i < 10; i++) begin @(negedge clk_i); if (ack_o) acks++; end
    chk("held_req_acks", acks, 1);
    req_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; acks = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk_i); if (ack_o) acks++; end
    chk("rereq_acks", acks, 1);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset in the middle of a multi-word write
    access(1'b1, 0, 16'hAAAA, 8'h0);
    access(1'b1, 1, 16'hBBBB, 8'h0);
    req_i = 1'b1; we_i = 1'b1; addr_i = 5'd0; wdata_i = 16'hCCCC;
    @(posedge clk_i); #1 res_i = 1'b1;
    @(negedge clk_i);
    chk("abort_ack", ack_o, 1'b0);
    req_i = 1'b0;
    @(negedge clk_i); res_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    access(1'b1, 2, 16'h1234, 8'h0);
    chk("commit_after_reset", mac_adr_o, 48'h123400000000);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 21));
      wd = 16'($urandom);
      if (a == 11) wd[0] = ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      access(rw, a, wd, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
